// File: rtl/matched_filter_pkg.sv
// Shared types and default widths for the matched-filter trigger block.
package matched_filter_pkg;

  localparam int DEF_NBITS  = 18;
  localparam int DEF_NSAMPS = 8;
  localparam int DEF_TBITS  = 32;

  // Trigger search states; the encoding is exported on state_o for debug.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_PENDING = 2'd2,
    ST_HOLDOFF = 2'd3
  } state_t;

  // Width of a sample index; at least one bit so a single-sample build still elaborates.
  function automatic int sel_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/matched_filter_trigger_sat_abs.sv
// Registered saturating absolute value: NBITS two's complement in, NBITS-1 magnitude out.
module sat_abs #(
  parameter int NBITS = 18
) (
  input  logic             aclk,
  input  logic             rst,
  input  logic [NBITS-1:0] data_i,
  output logic [NBITS-2:0] mag_o
);

  localparam logic [NBITS-1:0] MOST_NEG = {1'b1, {(NBITS-1){1'b0}}};

  logic [NBITS-2:0] w_neg;
  logic [NBITS-2:0] w_mag;
  logic [NBITS-2:0] r_mag;

  // |x| < 2^(NBITS-1) for every input except the most negative one, so the
  // low NBITS-1 bits of the negation are exact.
  assign w_neg = ~data_i[NBITS-2:0] + {{(NBITS-2){1'b0}}, 1'b1};

  // Pick magnitude: saturate the one unrepresentable input, negate negatives.
  always_comb begin
    w_mag = data_i[NBITS-2:0];
    if (data_i == MOST_NEG) begin
      w_mag = '1;
    end else if (data_i[NBITS-1]) begin
      w_mag = w_neg;
    end
  end

  // Output register.
  always_ff @(posedge aclk or posedge rst) begin
    if (rst) begin
      r_mag <= '0;
    end else begin
      r_mag <= w_mag;
    end
  end

  assign mag_o = r_mag;

endmodule

// File: rtl/matched_filter_trigger.sv
// Matched-filter trigger: magnitude, threshold compare, first-hit select and a
// holdoff-guarded trigger record handed out over a valid/ready port.
//
// Record handshake: trig_valid_o rises with a complete record and holds it
// stable until a cycle where trig_valid_o and trig_ready_i are both high; that
// cycle transfers the record. trig_valid_o is a pure register output and never
// depends on trig_ready_i; ready without valid is ignored.
module matched_filter_trigger
  import matched_filter_pkg::*;
#(
  parameter  int NBITS  = DEF_NBITS,
  parameter  int NSAMPS = DEF_NSAMPS,
  parameter  int TBITS  = DEF_TBITS,
  localparam int SBITS  = sel_bits(NSAMPS)
) (
  input  logic                    aclk,
  input  logic                    rst,
  input  logic [NBITS*NSAMPS-1:0] data_i,
  input  logic [NBITS-2:0]        threshold_i,
  input  logic [7:0]              holdoff_i,
  input  logic                    enable_i,
  output logic                    trig_valid_o,
  input  logic                    trig_ready_i,
  output logic [TBITS-1:0]        trig_time_o,
  output logic [SBITS-1:0]        trig_sample_o,
  output logic [NBITS-2:0]        trig_mag_o,
  output logic [15:0]             missed_o,
  output logic [1:0]              state_o
);

  logic [TBITS-1:0]               r_cnt;
  logic [TBITS-1:0]               r_ts1;
  logic [TBITS-1:0]               r_ts2;
  logic [NSAMPS-1:0][NBITS-2:0]   w_mag1;
  logic [NSAMPS-1:0][NBITS-2:0]   r_mag2;
  logic [NSAMPS-1:0]              r_hit2;

  logic                           w_any;
  logic [SBITS-1:0]               w_sel;
  logic [NBITS-2:0]               w_sel_mag;

  state_t                         r_state;
  state_t                         w_next;
  logic                           w_load;
  logic [7:0]                     r_hold;
  logic [TBITS-1:0]               r_time;
  logic [SBITS-1:0]               r_sample;
  logic [NBITS-2:0]               r_mag;
  logic [15:0]                    r_missed;

  // Free-running timestamp, wraps naturally at all-ones.
  always_ff @(posedge aclk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + {{(TBITS-1){1'b0}}, 1'b1};
    end
  end

  // Stage 1: one registered magnitude per sample.
  for (genvar g = 0; g < NSAMPS; g++) begin : g_abs
    sat_abs #(.NBITS(NBITS)) u_abs (
      .aclk   (aclk),
      .rst    (rst),
      .data_i (data_i[NBITS*g +: NBITS]),
      .mag_o  (w_mag1[g])
    );
  end

  // Timestamp delay line matching the two data stages.
  always_ff @(posedge aclk or posedge rst) begin
    if (rst) begin
      r_ts1 <= '0;
      r_ts2 <= '0;
    end else begin
      r_ts1 <= r_cnt;
      r_ts2 <= r_ts1;
    end
  end

  // Stage 2: strict threshold compare, magnitudes carried alongside.
  always_ff @(posedge aclk or posedge rst) begin
    if (rst) begin
      r_hit2 <= '0;
      r_mag2 <= '0;
    end else begin
      for (int i = 0; i < NSAMPS; i++) begin
        r_hit2[i] <= (w_mag1[i] > threshold_i);
      end
      r_mag2 <= w_mag1;
    end
  end

  // Priority encoder: the earliest (lowest index) hit wins.
  always_comb begin
    w_any     = |r_hit2;
    w_sel     = '0;
    w_sel_mag = r_mag2[0];
    for (int i = NSAMPS - 1; i >= 0; i--) begin
      if (r_hit2[i]) begin
        w_sel     = SBITS'(i);
        w_sel_mag = r_mag2[i];
      end
    end
  end

  // FSM state register.
  always_ff @(posedge aclk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // FSM next state; disable wins over a hit in ARMED, never aborts PENDING.
  always_comb begin
    w_next = r_state;
    w_load = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (enable_i) w_next = ST_ARMED;
      end
      ST_ARMED: begin
        if (!enable_i) begin
          w_next = ST_IDLE;
        end else if (w_any) begin
          w_next = ST_PENDING;
          w_load = 1'b1;
        end
      end
      ST_PENDING: begin
        if (trig_ready_i) begin
          if (holdoff_i != 8'd0) w_next = ST_HOLDOFF;
          else if (enable_i)     w_next = ST_ARMED;
          else                   w_next = ST_IDLE;
        end
      end
      ST_HOLDOFF: begin
        if (!enable_i)             w_next = ST_IDLE;
        else if (r_hold <= 8'd1)   w_next = ST_ARMED;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Holdoff countdown, loaded with holdoff_i on the accepting handshake.
  always_ff @(posedge aclk or posedge rst) begin
    if (rst) begin
      r_hold <= 8'd0;
    end else if (r_state == ST_PENDING && trig_ready_i) begin
      r_hold <= holdoff_i;
    end else if (r_state == ST_HOLDOFF && r_hold != 8'd0) begin
      r_hold <= r_hold - 8'd1;
    end
  end

  // Trigger record, captured only when ARMED takes a hit.
  always_ff @(posedge aclk or posedge rst) begin
    if (rst) begin
      r_time   <= '0;
      r_sample <= '0;
      r_mag    <= '0;
    end else if (w_load) begin
      r_time   <= r_ts2;
      r_sample <= w_sel;
      r_mag    <= w_sel_mag;
    end
  end

  // Saturating count of hit blocks dropped while a record is busy.
  always_ff @(posedge aclk or posedge rst) begin
    if (rst) begin
      r_missed <= 16'd0;
    end else if ((r_state == ST_PENDING || r_state == ST_HOLDOFF) && w_any &&
                 r_missed != 16'hFFFF) begin
      r_missed <= r_missed + 16'd1;
    end
  end

  assign trig_valid_o  = (r_state == ST_PENDING);
  assign trig_time_o   = r_time;
  assign trig_sample_o = r_sample;
  assign trig_mag_o    = r_mag;
  assign missed_o      = r_missed;
  assign state_o       = r_state;

endmodule

// File: tb/tb_matched_filter_trigger.sv
// Bench for matched_filter_trigger: directed scenarios plus random traffic,
// all checked against a block-level reference model.
module tb_matched_filter_trigger;

  localparam int NBITS  = 18;
  localparam int NSAMPS = 8;
  localparam int TBITS  = 10;
  localparam int SBITS  = 3;
  localparam int MAGMAX = (1 << (NBITS - 1)) - 1;

  logic                    aclk = 1'b0;
  logic                    rst  = 1'b1;
  logic [NBITS*NSAMPS-1:0] data_i = '0;
  logic [NBITS-2:0]        threshold_i = 17'd1000;
  logic [7:0]              holdoff_i = 8'd0;
  logic                    enable_i = 1'b0;
  logic                    trig_ready_i = 1'b0;
  logic                    trig_valid_o;
  logic [TBITS-1:0]        trig_time_o;
  logic [SBITS-1:0]        trig_sample_o;
  logic [NBITS-2:0]        trig_mag_o;
  logic [15:0]             missed_o;
  logic [1:0]              state_o;

  matched_filter_trigger #(.NBITS(NBITS), .NSAMPS(NSAMPS), .TBITS(TBITS)) dut (
    .aclk          (aclk),
    .rst           (rst),
    .data_i        (data_i),
    .threshold_i   (threshold_i),
    .holdoff_i     (holdoff_i),
    .enable_i      (enable_i),
    .trig_valid_o  (trig_valid_o),
    .trig_ready_i  (trig_ready_i),
    .trig_time_o   (trig_time_o),
    .trig_sample_o (trig_sample_o),
    .trig_mag_o    (trig_mag_o),
    .missed_o      (missed_o),
    .state_o       (state_o)
  );

  // ---------------- clock / watchdog ----------------
  always #5 aclk = ~aclk;

  initial begin
    #2000000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- scoreboard ----------------
  int n_total = 0;
  int n_bad   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s obs=%0d exp=%0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // A block seen by the decision logic: first over-threshold sample, if any.
  typedef struct {
    bit hit;
    int idx;
    int mag;
    int ts;
  } blk_t;

  blk_t pipe_q[$];     // blocks in flight, oldest first; two cycles deep
  int   m_cnt;         // timestamp of the cycle currently being presented
  bit   m_pending;     // a record is waiting for the consumer
  int   m_hold_left;   // clocks of holdoff still to serve
  bit   m_armed;       // searching for a hit
  int   m_missed;
  blk_t m_rec;

  function automatic blk_t eval_block(input logic [NBITS*NSAMPS-1:0] d, input int thr,
                                      input int ts);
    blk_t b;
    b.hit = 1'b0;
    b.idx = 0;
    b.mag = 0;
    b.ts  = ts;
    for (int i = 0; i < NSAMPS; i++) begin
      logic signed [NBITS-1:0] f;
      int v;
      int m;
      f = d[NBITS*i +: NBITS];
      v = int'(f);
      m = (v < 0) ? -v : v;
      if (m > MAGMAX) m = MAGMAX;
      if (!b.hit && m > thr) begin
        b.hit = 1'b1;
        b.idx = i;
        b.mag = m;
      end
    end
    return b;
  endfunction

  function automatic void model_reset();
    blk_t z;
    z.hit = 1'b0; z.idx = 0; z.mag = 0; z.ts = 0;
    pipe_q.delete();
    pipe_q.push_back(z);
    pipe_q.push_back(z);
    m_cnt       = 0;
    m_pending   = 1'b0;
    m_hold_left = 0;
    m_armed     = 1'b0;
    m_missed    = 0;
    m_rec       = z;
  endfunction

  // Advance the model across one rising edge using the inputs held before it.
  function automatic void model_edge();
    blk_t b;
    pipe_q.push_back(eval_block(data_i, int'(threshold_i), m_cnt));
    m_cnt = (m_cnt + 1) % (1 << TBITS);
    b = pipe_q.pop_front();
    if (m_pending) begin
      if (b.hit && m_missed < 65535) m_missed++;
      if (trig_ready_i) begin
        m_pending = 1'b0;
        if (holdoff_i != 8'd0) m_hold_left = int'(holdoff_i);
        else                   m_armed = enable_i;
      end
    end else if (m_hold_left > 0) begin
      if (b.hit && m_missed < 65535) m_missed++;
      if (!enable_i) begin
        m_hold_left = 0;
        m_armed     = 1'b0;
      end else if (m_hold_left == 1) begin
        m_hold_left = 0;
        m_armed     = 1'b1;
      end else begin
        m_hold_left--;
      end
    end else if (m_armed) begin
      if (!enable_i) begin
        m_armed = 1'b0;
      end else if (b.hit) begin
        m_armed   = 1'b0;
        m_pending = 1'b1;
        m_rec     = b;
      end
    end else if (enable_i) begin
      m_armed = 1'b1;
    end
  endfunction

  task automatic compare_outputs();
    check("valid", trig_valid_o, m_pending);
    check("missed", missed_o, m_missed);
    if (m_pending) begin
      check("rec_time", trig_time_o, m_rec.ts);
      check("rec_sample", trig_sample_o, m_rec.idx);
      check("rec_mag", trig_mag_o, m_rec.mag);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge aclk);
    #1;
    if (!rst) begin
      model_edge();
      compare_outputs();
    end
  endtask

  task automatic wait_cnt(input int target);
    int k;
    k = 0;
    while (m_cnt != target && k < 1100) begin
      step();
      k++;
    end
    check("wait_cnt", m_cnt, target);
  endtask

  task automatic wait_valid(input int budget);
    int k;
    k = 0;
    while (!trig_valid_o && k < budget) begin
      step();
      k++;
    end
    check("wait_valid", trig_valid_o, 1'b1);
  endtask

  // Present one block with a single non-zero sample for one clock.
  task automatic present(input int idx, input int val);
    data_i = '0;
    data_i[NBITS*idx +: NBITS] = NBITS'(val);
    step();
    data_i = '0;
  endtask

  function automatic logic [NBITS-1:0] rnd_sample(input int thr, input int pct);
    int m;
    logic [NBITS-1:0] s;
    if (int'($urandom_range(99)) < pct) begin
      case ($urandom_range(3))
        0:       m = thr;
        1:       m = thr + 1;
        2:       m = thr + 1 + int'($urandom_range(3000));
        default: m = -1;
      endcase
    end else begin
      m = int'($urandom_range(thr));
    end
    if (m < 0) begin
      s = {1'b1, {(NBITS-1){1'b0}}};
    end else begin
      if (m > MAGMAX) m = MAGMAX;
      s = NBITS'(m);
      if ($urandom_range(1) == 1) s = -s;
    end
    return s;
  endfunction

  // ---------------- test sequence ----------------
  int n_valid;
  int gap;

  initial begin
    model_reset();
    repeat (3) @(posedge aclk);
    #1;
    check("rst_valid", trig_valid_o, 1'b0);
    check("rst_time", trig_time_o, 0);
    check("rst_sample", trig_sample_o, 0);
    check("rst_mag", trig_mag_o, 0);
    check("rst_missed", missed_o, 0);
    rst = 1'b0;
    model_reset();

    // Single hit at timestamp 100, three-cycle latency.
    enable_i     = 1'b1;
    trig_ready_i = 1'b1;
    wait_cnt(100);
    present(5, 1200);
    step();
    check("lat_n2_valid", trig_valid_o, 1'b0);
    step();
    check("lat_n3_valid", trig_valid_o, 1'b1);
    check("t100_time", trig_time_o, 100);
    check("t100_sample", trig_sample_o, 5);
    check("t100_mag", trig_mag_o, 1200);
    repeat (4) step();

    // Two hits in one block: earliest index wins.
    data_i = '0;
    data_i[NBITS*2 +: NBITS] = NBITS'(-1500);
    data_i[NBITS*6 +: NBITS] = NBITS'(2000);
    step();
    data_i = '0;
    repeat (2) step();
    check("multi_valid", trig_valid_o, 1'b1);
    check("multi_sample", trig_sample_o, 2);
    check("multi_mag", trig_mag_o, 1500);
    repeat (3) step();

    // Most negative input saturates and still exceeds a near-full threshold.
    enable_i = 1'b0;
    repeat (3) step();
    threshold_i = 17'd131070;
    repeat (2) step();
    enable_i = 1'b1;
    repeat (2) step();
    present(3, -131072);
    repeat (2) step();
    check("sat_valid", trig_valid_o, 1'b1);
    check("sat_sample", trig_sample_o, 3);
    check("sat_mag", trig_mag_o, 131071);
    enable_i = 1'b0;
    repeat (3) step();
    threshold_i = 17'd1000;
    repeat (2) step();
    enable_i = 1'b1;
    repeat (2) step();

    // Consumer stalls under continuous hits, then holdoff of 4.
    trig_ready_i = 1'b0;
    holdoff_i    = 8'd4;
    data_i       = '0;
    data_i[NBITS*0 +: NBITS] = NBITS'(5000);
    wait_valid(10);
    repeat (10) step();
    check("stall_missed", missed_o, 10);
    trig_ready_i = 1'b1;
    step();
    gap = 1;
    while (!trig_valid_o && gap < 20) begin
      step();
      gap++;
    end
    check("holdoff_gap", gap, 6);
    data_i = '0;
    repeat (10) step();

    // No holdoff, continuous hits: records on alternate cycles.
    holdoff_i = 8'd0;
    data_i[NBITS*7 +: NBITS] = NBITS'(-4000);
    repeat (4) step();
    n_valid = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (trig_valid_o) n_valid++;
    end
    check("alt_count", n_valid, 10);
    data_i = '0;
    repeat (4) step();

    // Asynchronous reset while a record is pending.
    trig_ready_i = 1'b0;
    present(1, 3000);
    wait_valid(10);
    #3;
    rst = 1'b1;
    #1;
    check("arst_valid", trig_valid_o, 1'b0);
    check("arst_time", trig_time_o, 0);
    check("arst_sample", trig_sample_o, 0);
    check("arst_mag", trig_mag_o, 0);
    check("arst_missed", missed_o, 0);
    repeat (2) @(posedge aclk);
    #1;
    rst = 1'b0;
    model_reset();
    trig_ready_i = 1'b1;
    repeat (2) step();
    wait_cnt(5);
    present(4, -2500);
    repeat (2) step();
    check("restart_time", trig_time_o, 5);

    // Timestamp wrap: last count before wrap, then the first after it.
    wait_cnt((1 << TBITS) - 1);
    present(6, 1800);
    step();
    present(0, 1700);
    check("wrap_valid", trig_valid_o, 1'b1);
    check("wrap_time", trig_time_o, (1 << TBITS) - 1);
    repeat (4) step();

    // Random traffic.
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < NSAMPS; i++) begin
        data_i[NBITS*i +: NBITS] = rnd_sample(1000, 3);
      end
      if ($urandom_range(99) < 2) enable_i = ~enable_i;
      trig_ready_i = ($urandom_range(99) < 60);
      holdoff_i    = 8'($urandom_range(6));
      step();
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/matched_filter_trigger.md
MATCHED_FILTER_TRIGGER -- requirements
Module: matched_filter_trigger

Interface
REQ-001 SHALL have parameter NBITS, default 18, width of one filtered sample (two's complement).
REQ-002 SHALL have parameter NSAMPS, default 8, samples per clock (SSR), index 0 earliest, NSAMPS-1 latest.
REQ-003 SHALL have parameter TBITS, default 32, timestamp counter width.
REQ-004 SHALL have port aclk  input  1  sole clock; all logic rising-edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port data_i  input  NBITS*NSAMPS  filtered samples, sample i at bits [NBITS*i +: NBITS], new block every cycle.
REQ-007 SHALL have port threshold_i  input  NBITS-1  unsigned magnitude threshold, quasi-static.
REQ-008 SHALL have port holdoff_i  input  8  holdoff length in clocks after each accepted trigger.
REQ-009 SHALL have port enable_i  input  1  level; trigger search active when high.
REQ-010 SHALL have port trig_valid_o  output  1  trigger record available.
REQ-011 SHALL have port trig_ready_i  input  1  consumer accepts record when high with trig_valid_o.
REQ-012 SHALL have port trig_time_o  output  TBITS  timestamp of the block containing the trigger.
REQ-013 SHALL have port trig_sample_o  output  $clog2(NSAMPS)  index of earliest over-threshold sample in that block.
REQ-014 SHALL have port trig_mag_o  output  NBITS-1  magnitude of that sample.
REQ-015 SHALL have port missed_o  output  16  count of over-threshold blocks discarded while busy, saturating at 65535.

Function
REQ-016 SHALL run a free-running TBITS counter incrementing every clock, wrapping to 0 after all-ones.
REQ-017 SHALL stage 1 (registered): per-sample magnitude |x|, NBITS-1 bits; most-negative input saturates to 2^(NBITS-1)-1.
REQ-018 SHALL stage 2 (registered): hit[i] = magnitude[i] > threshold_i (strict); carry magnitudes and block timestamp.
REQ-019 SHALL stamp each block with the counter value on the cycle data_i is presented (delay-matched through stages).
REQ-020 SHALL stage 3: FSM; block presented at cycle N with a hit SHALL raise trig_valid_o at cycle N+3 when ARMED.
REQ-021 SHALL select the lowest hit index when multiple samples in one block exceed threshold.
REQ-022 SHALL implement states IDLE, ARMED, PENDING, HOLDOFF.
REQ-023 IDLE->ARMED when enable_i high; ARMED->IDLE when enable_i low.
REQ-024 ARMED->PENDING on any hit; record loaded, trig_valid_o high from that cycle.
REQ-025 PENDING: trig_valid_o and record SHALL stay stable until trig_valid_o & trig_ready_i; enable_i low SHALL NOT abort it.
REQ-026 PENDING->HOLDOFF on handshake if holdoff_i != 0; directly to ARMED (or IDLE if enable_i low) if holdoff_i == 0.
REQ-027 HOLDOFF SHALL last exactly holdoff_i clocks (holdoff_i sampled at handshake), then ARMED, or IDLE if enable_i low.
REQ-028 HOLDOFF->IDLE immediately if enable_i falls.
REQ-029 Hits arriving in PENDING or HOLDOFF SHALL increment missed_o by 1 per block; hits in IDLE SHALL NOT count.
REQ-030 Valid SHALL never depend combinationally on trig_ready_i; ready may be high without valid (no effect).

Reset
REQ-031 rst SHALL asynchronously force state IDLE, counter 0, pipeline registers 0, trig_valid_o 0, trig_time_o 0, trig_sample_o 0, trig_mag_o 0, missed_o 0.
REQ-032 rst mid-PENDING SHALL drop trig_valid_o with no handshake; record lost.
REQ-033 First hit after rst release SHALL be detectable no earlier than 3 clocks after enable_i and data valid.

Structure
REQ-034 Shared package matched_filter_pkg SHALL hold the FSM state enum and default widths (NBITS, NSAMPS, TBITS).
REQ-035 One sub-module sat_abs (NBITS in, NBITS-1 out, registered) SHALL be instantiated NSAMPS times.
REQ-036 Priority encoder and FSM SHALL reside in the top module.

Verification
REQ-037 threshold 1000, enable high, ready high, sample 5 = +1200 at counter 100 -> valid at N+3, time 100, sample 5, mag 1200.
REQ-038 Samples 2 = -1500 and 6 = +2000 same block, threshold 1000 -> sample 2, mag 1500.
REQ-039 Sample = -131072, threshold 131070 -> mag 131071, trigger fires.
REQ-040 ready low 10 clocks, hits every block -> record unchanged, missed_o increments 1 per hit block; after accept, holdoff_i 4 -> next trigger no earlier than 5 clocks after handshake.
REQ-041 holdoff_i 0, continuous hits, ready high -> trigger every other cycle (PENDING/ARMED alternate); missed_o counts PENDING-cycle hits.
REQ-042 rst asserted while PENDING -> all outputs 0 same cycle asynchronously; counter restarts at 0; counter wraps 0xFFFFFFFF->0.
